aes_req_arbiter: RTL and testbench
==================================

Name: aes_req_arbiter

Overview:
- Shares one AES engine (key schedule plus round datapath) between NREQ independent requesters, e.g. USB OUT-path encrypt and IN-path decrypt/host key loader.
- Each request is either a key load or a 128-bit block operation.
- Requesters are granted round-robin, and the block drives the engine's start/key-load strobes.
- Each result is returned to its owner with a valid/ready handshake.
- Guards against block operations issued before any key is loaded, and against a hung engine.

Parameters:
NREQ, 2, number of requesters (2..4)
TIMEOUT_CYC, 64, max cycles from eng_start to eng_done before abort
CW, 7, timeout counter width (must hold TIMEOUT_CYC)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  NREQ  request pending, per requester
req_ready  out  NREQ  request accepted (one-hot, single-cycle pulse)
req_is_key  in  NREQ  1 = key load, 0 = block operation
req_data  in  NREQ*128  per-requester key or block; requester i uses bits [128*i +: 128]
rsp_valid  out  NREQ  response available to owner (one-hot)
rsp_ready  in  NREQ  owner consumes response
rsp_data  out  128  engine result; 0 for key load or error
rsp_err  out  1  1 = no key loaded, or timeout
eng_start  out  1  one-cycle start strobe to engine
eng_key_load  out  1  qualifies eng_start as key expansion
eng_din  out  128  operand to engine, held stable from start to done
eng_done  in  1  engine completion pulse
eng_dout  in  128  engine result, valid with eng_done
busy  out  1  not IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - key_loaded = 0.
  - The round-robin pointer rr_ptr = 0.
  - The timeout counter is 0.
- rst asserted mid-operation aborts the job. There is no response, and any eng_done that arrives afterwards is ignored.
- IDLE:
  - Grant the first valid requester searching from rr_ptr upward, with wrap.
  - In the same cycle, pulse req_ready[g] and latch g, req_is_key[g] and req_data[g].
  - Set rr_ptr = (g+1) mod NREQ.
  - Go to ISSUE. If no request is valid, stay in IDLE.
- ISSUE, block op with key_loaded = 0: do not touch the engine. Set rsp_err = 1 and rsp_data = 0, then go to RESP.
- ISSUE, otherwise: assert eng_start for one cycle, with eng_key_load = latched is_key. Clear the counter and go to WAIT.
- eng_din is driven from the latched operand in every non-IDLE state.
- WAIT:
  - Increment the counter each cycle.
  - On eng_done:
    - Capture eng_dout, or 0 for a key load.
    - Set rsp_err = 0.
    - If the job was a key load, set key_loaded = 1.
    - Go to RESP.
  - If the counter reaches TIMEOUT_CYC - 1 without eng_done:
    - Set rsp_err = 1 and rsp_data = 0.
    - If the job was a key load, clear key_loaded.
    - Go to RESP.
  - An eng_done in the same cycle as the timeout wins, and no error is reported.
- RESP:
  - Hold rsp_valid[g], rsp_data and rsp_err stable until rsp_ready[g]=1, then go to IDLE.
  - rsp_ready on non-owner lines is ignored.
  - A response that is never consumed stalls all requesters; this is by design.
- Latency, request accept to rsp_valid:
  - Engine path: 2 + engine latency cycles.
  - No-key error path: 2 cycles.
  - The earliest next grant is the cycle after the rsp handshake.
- Fairness: a continuously requesting channel is granted at most once in every NREQ grants while others are pending.
- Stray eng_done outside WAIT is ignored.
- A new key load replaces the previous key. There is no per-requester key; all requesters share the last loaded key.

Decomposition:
- aes_pkg holds:
  - the state enum: IDLE, ISSUE, WAIT, RESP;
  - the AES_BLK_W = 128 constant;
  - a req_t struct {is_key, data}.
- One sub-module: aes_rr_pick, a combinational round-robin priority picker. It takes req_valid and rr_ptr and produces a one-hot grant and an index. It is reusable by the USB endpoint arbiter.

Test Plan:
- Block op on req 0 right after reset -> no eng_start. rsp_valid[0] 2 cycles later with rsp_err=1, rsp_data=0.
- Key load on req 1 with key 000102..0F, engine model done after 11 cycles -> one eng_start with eng_key_load=1. rsp_valid[1] with rsp_err=0, rsp_data=0. busy drops the cycle after rsp_ready.
- After the key load, block 00112233445566778899AABBCCDDEEFF on req 0 -> eng_din matches the block. rsp_data = 69C4E0D86A7B0430D8CDB78070B4C55A (FIPS-197 C.1).
- Both requesters valid continuously with 4 block ops each -> grants alternate 0,1,0,1. Each response is routed only to its owner.
- Engine model never asserts eng_done -> rsp_err=1 exactly TIMEOUT_CYC cycles after eng_start. The arbiter returns to IDLE and grants the next requester.
- rst pulsed during WAIT, with eng_done arriving 2 cycles later -> all outputs 0. No rsp_valid, and key_loaded = 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES request arbiter and its helpers.
package aes_pkg;

    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef struct packed {
        logic                 is_key;
        logic [AES_BLK_W-1:0] data;
    } req_t;

endpackage

// File: rtl/aes_rr_pick.sv
// Combinational round-robin picker: first valid line at or above rr_ptr, wrapping.
module aes_rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [PW-1:0]   rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            any
);

    localparam int SW = PW + 1;

    logic [SW-1:0] cand;

    // Walk the lines starting at rr_ptr and keep the first valid one found.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + SW'(k);
            if (cand >= SW'(NREQ)) begin
                cand = cand - SW'(NREQ);
            end
            if (!any && req_valid[cand[PW-1:0]]) begin
                any                    = 1'b1;
                grant_idx              = cand[PW-1:0];
                grant[cand[PW-1:0]]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one AES engine between NREQ requesters: round-robin grant, engine
// start/key-load sequencing, no-key and hung-engine guards, per-owner response.
module aes_req_arbiter
    import aes_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 64,
    parameter int CW          = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0]           req_is_key,
    input  logic [NREQ*AES_BLK_W-1:0] req_data,
    output logic [NREQ-1:0]           rsp_valid,
    input  logic [NREQ-1:0]           rsp_ready,
    output logic [AES_BLK_W-1:0]      rsp_data,
    output logic                      rsp_err,
    output logic                      eng_start,
    output logic                      eng_key_load,
    output logic [AES_BLK_W-1:0]      eng_din,
    input  logic                      eng_done,
    input  logic [AES_BLK_W-1:0]      eng_dout,
    output logic                      busy
);

    localparam int PW = (NREQ > 2) ? 2 : 1;

    arb_state_t    state;
    logic          key_loaded;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] owner;
    req_t          op;
    logic [CW-1:0] tmo_cnt;
    logic [CW-1:0] cnt_next;
    logic          tmo_hit;

    logic [NREQ-1:0] pick_grant;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;
    req_t            cand_req;

    aes_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // Gather the picked requester's kind and operand for latching at grant.
    always_comb begin
        cand_req.is_key = req_is_key[pick_idx];
        cand_req.data   = req_data[AES_BLK_W*int'(pick_idx) +: AES_BLK_W];
    end

    // The accept pulse is same-cycle with the grant decision so the requester
    // sees the handshake while its data is still being latched.
    assign req_ready = (state == IDLE && pick_any && !rst) ? pick_grant : '0;
    assign busy      = (state != IDLE);
    assign eng_din   = (state != IDLE) ? op.data : '0;

    assign cnt_next  = tmo_cnt + CW'(1);
    assign tmo_hit   = (cnt_next == CW'(TIMEOUT_CYC - 1));

    // Main job sequencer: grant, issue to engine, wait with timeout, respond.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            key_loaded   <= 1'b0;
            rr_ptr       <= '0;
            owner        <= '0;
            op           <= '0;
            tmo_cnt      <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
            eng_start    <= 1'b0;
            eng_key_load <= 1'b0;
        end else begin
            eng_start    <= 1'b0;
            eng_key_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner  <= pick_idx;
                        op     <= cand_req;
                        rr_ptr <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
                        if (cand_req.is_key || key_loaded) begin
                            eng_start    <= 1'b1;
                            eng_key_load <= cand_req.is_key;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!op.is_key && !key_loaded) begin
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        rsp_valid <= NREQ'(1) << owner;
                        state     <= RESP;
                    end else begin
                        tmo_cnt <= '0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    tmo_cnt <= cnt_next;
                    if (eng_done) begin
                        rsp_data  <= op.is_key ? '0 : eng_dout;
                        rsp_err   <= 1'b0;
                        rsp_valid <= NREQ'(1) << owner;
                        if (op.is_key) begin
                            key_loaded <= 1'b1;
                        end
                        state <= RESP;
                    end else if (tmo_hit) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= NREQ'(1) << owner;
                        if (op.is_key) begin
                            key_loaded <= 1'b0;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= '0;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Scoreboard bench for aes_req_arbiter with a behavioural engine model.
module tb_aes_req_arbiter;

    localparam int NREQ        = 2;
    localparam int TIMEOUT_CYC = 64;
    localparam int CW          = 7;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_is_key;
    logic [NREQ*128-1:0]   req_data;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [127:0]          rsp_data;
    logic                  rsp_err;
    logic                  eng_start;
    logic                  eng_key_load;
    logic [127:0]          eng_din;
    logic                  eng_done;
    logic [127:0]          eng_dout;
    logic                  busy;

    aes_req_arbiter #(
        .NREQ        (NREQ),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CW          (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_key   (req_is_key),
        .req_data     (req_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .eng_start    (eng_start),
        .eng_key_load (eng_key_load),
        .eng_din      (eng_din),
        .eng_done     (eng_done),
        .eng_dout     (eng_dout),
        .busy         (busy)
    );

    typedef struct {
        int           ch;
        logic         is_key;
        logic [127:0] data;
    } job_t;

    typedef struct {
        int           ch;
        logic         err;
        logic [127:0] data;
        int           lat;
        int           acc_cyc;
        logic         is_to;
    } exp_t;

    job_t jobs[$];
    exp_t sb[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int eng_lat  = 11;
    int stray_at = -1;
    int starts   = 0;
    int start_cyc = 0;
    int hs_stage = 0;
    int model_ptr = 0;
    logic model_key = 1'b0;
    logic last_kl = 1'b0;
    logic last_acc_key = 1'b0;
    logic [127:0] last_acc_data = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] engFn(input logic [127:0] din);
        if (din == FIPS_PT) return FIPS_CT;
        return {din[63:0], din[127:64]} ^ 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_9696_6969;
    endfunction

    task applyStimulus(input int ch, input logic is_key, input logic [127:0] data);
        job_t j;
        j.ch     = ch;
        j.is_key = is_key;
        j.data   = data;
        jobs.push_back(j);
    endtask

    function automatic int findJob(input int ch);
        foreach (jobs[i]) if (jobs[i].ch == ch) return i;
        return -1;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Engine model: done L cycles after start (L = 0 means never), plus stray pulses.
    initial begin
        int pend;
        logic [127:0] din_cap;
        pend = 0;
        din_cap = '0;
        eng_done = 1'b0;
        eng_dout = '0;
        forever begin
            @(negedge clk);
            if (eng_start === 1'b1) begin
                starts++;
                last_kl   = eng_key_load;
                start_cyc = cyc;
                din_cap   = eng_din;
                checkOutput("eng_din_at_start", eng_din, last_acc_data);
                checkOutput("eng_key_load", 128'(eng_key_load), 128'(last_acc_key));
                pend = eng_lat;
            end
            if (eng_done && busy) checkOutput("eng_din_stable", eng_din, din_cap);
            @(posedge clk);
            #1;
            eng_done = 1'b0;
            eng_dout = '0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    eng_done = 1'b1;
                    eng_dout = engFn(din_cap);
                end
            end
            if (stray_at >= 0 && cyc == stray_at) begin
                eng_done = 1'b1;
                eng_dout = '1;
            end
        end
    end

    // Requester driver, grant model and response scoreboard.
    initial begin
        int exp_g;
        int idx;
        int c;
        job_t j;
        exp_t e;
        logic [NREQ-1:0] sv_valid;
        logic [127:0] sv_data;
        logic sv_err;
        req_valid  = '0;
        req_is_key = '0;
        req_data   = '0;
        rsp_ready  = '0;
        sv_valid   = '0;
        sv_data    = '0;
        sv_err     = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rsp_ready = '0;
                hs_stage  = 0;
            end else begin
                if (req_ready != '0) begin
                    exp_g = -1;
                    for (int k = 0; k < NREQ; k++) begin
                        c = (model_ptr + k) % NREQ;
                        if (exp_g < 0 && req_valid[c]) exp_g = c;
                    end
                    checkOutput("grant", 128'(req_ready), (exp_g < 0) ? 128'(0) : (128'(1) << exp_g));
                    idx = (exp_g < 0) ? -1 : findJob(exp_g);
                    if (idx >= 0) begin
                        j = jobs[idx];
                        jobs.delete(idx);
                        e.ch = exp_g;
                        e.acc_cyc = cyc;
                        e.is_to = 1'b0;
                        if (!j.is_key && !model_key) begin
                            e.err = 1'b1; e.data = '0; e.lat = 2;
                        end else if (eng_lat == 0 || eng_lat > TIMEOUT_CYC - 1) begin
                            e.err = 1'b1; e.data = '0; e.lat = TIMEOUT_CYC + 1; e.is_to = 1'b1;
                            if (j.is_key) model_key = 1'b0;
                        end else begin
                            e.err = 1'b0;
                            e.data = j.is_key ? 128'(0) : engFn(j.data);
                            e.lat = 2 + eng_lat;
                            if (j.is_key) model_key = 1'b1;
                        end
                        sb.push_back(e);
                        last_acc_data = j.data;
                        last_acc_key  = j.is_key;
                        model_ptr = (exp_g + 1) % NREQ;
                    end
                end
                case (hs_stage)
                    0: begin
                        if (rsp_valid != '0) begin
                            if (sb.size() == 0) begin
                                checkOutput("rsp_unexpected", 128'(rsp_valid), 128'(0));
                            end else begin
                                e = sb.pop_front();
                                checkOutput("rsp_owner", 128'(rsp_valid), 128'(1) << e.ch);
                                checkOutput("rsp_err", 128'(rsp_err), 128'(e.err));
                                checkOutput("rsp_data", rsp_data, e.data);
                                checkOutput("rsp_latency", 128'(cyc - e.acc_cyc), 128'(e.lat));
                                if (e.is_to) checkOutput("tmo_from_start", 128'(cyc - start_cyc), 128'(TIMEOUT_CYC));
                            end
                            sv_valid  = rsp_valid;
                            sv_data   = rsp_data;
                            sv_err    = rsp_err;
                            rsp_ready = ~rsp_valid;
                            hs_stage  = 1;
                        end
                    end
                    1: begin
                        checkOutput("rsp_hold_valid", 128'(rsp_valid), 128'(sv_valid));
                        checkOutput("rsp_hold_data", rsp_data, sv_data);
                        checkOutput("rsp_hold_err", 128'(rsp_err), 128'(sv_err));
                        rsp_ready = sv_valid;
                        hs_stage  = 2;
                    end
                    default: begin
                        checkOutput("rsp_drop_valid", 128'(rsp_valid), 128'(0));
                        checkOutput("busy_drop", 128'(busy), 128'(0));
                        rsp_ready = '0;
                        hs_stage  = 0;
                    end
                endcase
            end
            @(posedge clk);
            #1;
            for (int ch = 0; ch < NREQ; ch++) begin
                idx = findJob(ch);
                if (idx >= 0) begin
                    req_valid[ch]            = 1'b1;
                    req_is_key[ch]           = jobs[idx].is_key;
                    req_data[128*ch +: 128]  = jobs[idx].data;
                end else begin
                    req_valid[ch]            = 1'b0;
                    req_is_key[ch]           = 1'b0;
                    req_data[128*ch +: 128]  = '0;
                end
            end
        end
    end

    task resetCheck(input string tag);
        checkOutput({tag, "_req_ready"}, 128'(req_ready), 128'(0));
        checkOutput({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(0));
        checkOutput({tag, "_rsp_data"}, rsp_data, 128'(0));
        checkOutput({tag, "_rsp_err"}, 128'(rsp_err), 128'(0));
        checkOutput({tag, "_eng_start"}, 128'(eng_start), 128'(0));
        checkOutput({tag, "_eng_key_load"}, 128'(eng_key_load), 128'(0));
        checkOutput({tag, "_eng_din"}, eng_din, 128'(0));
        checkOutput({tag, "_busy"}, 128'(busy), 128'(0));
    endtask

    task waitDrain(input int budget);
        int n;
        n = 0;
        while ((jobs.size() != 0 || sb.size() != 0 || busy || hs_stage != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) checkOutput("drain_timeout", 128'(n), 128'(0));
        @(posedge clk);
        #2;
    endtask

    // Watchdog in case something stalls outside the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence.
    initial begin
        int s0;
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetCheck("reset");
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Block op before any key: error response, engine untouched.
        applyStimulus(0, 1'b0, FIPS_PT);
        waitDrain(200);
        checkOutput("no_start_without_key", 128'(starts), 128'(0));

        // Key load on requester 1.
        eng_lat = 11;
        applyStimulus(1, 1'b1, FIPS_KEY);
        waitDrain(200);
        checkOutput("key_start_count", 128'(starts), 128'(1));
        checkOutput("key_start_kl", 128'(last_kl), 128'(1));

        // FIPS-197 C.1 block.
        applyStimulus(0, 1'b0, FIPS_PT);
        waitDrain(200);

        // Both requesters busy: grants must alternate.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1'b0, rnd128());
            applyStimulus(1, 1'b0, rnd128());
        end
        waitDrain(600);

        // Done on the last allowed cycle wins; one cycle later is a timeout.
        eng_lat = TIMEOUT_CYC - 1;
        applyStimulus(1, 1'b0, rnd128());
        waitDrain(300);
        eng_lat = TIMEOUT_CYC;
        applyStimulus(0, 1'b0, rnd128());
        waitDrain(300);

        // Hung engine: both time out, second is granted after the first.
        eng_lat = 0;
        applyStimulus(0, 1'b0, rnd128());
        applyStimulus(1, 1'b0, rnd128());
        waitDrain(400);

        // Timed-out key load forgets the key.
        applyStimulus(1, 1'b1, rnd128());
        waitDrain(300);
        eng_lat = 11;
        s0 = starts;
        applyStimulus(0, 1'b0, rnd128());
        waitDrain(200);
        checkOutput("no_start_after_key_tmo", 128'(starts), 128'(s0));

        // Reset during WAIT with a late eng_done.
        applyStimulus(0, 1'b1, rnd128());
        waitDrain(200);
        eng_lat = 0;
        s0 = starts;
        applyStimulus(1, 1'b0, rnd128());
        n = 0;
        while (starts == s0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        if (n >= 30) checkOutput("reset_test_start_timeout", 128'(n), 128'(0));
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        sb.delete();
        jobs.delete();
        model_key = 1'b0;
        model_ptr = 0;
        stray_at = cyc + 2;
        s0 = starts;
        @(negedge clk);
        resetCheck("midop_reset");
        repeat (6) @(posedge clk);
        @(negedge clk);
        checkOutput("stray_busy", 128'(busy), 128'(0));
        checkOutput("stray_rsp_valid", 128'(rsp_valid), 128'(0));
        @(posedge clk);
        #2;
        eng_lat = 11;
        applyStimulus(0, 1'b0, rnd128());
        waitDrain(200);
        checkOutput("key_cleared_no_start", 128'(starts), 128'(s0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
